// File: rtl/menu_pkg.sv
// menu_pkg: button geometry, colours and FSM encoding for the menu select stage
package menu_pkg;
    localparam logic [11:0] BTN_X      = 12'd384;
    localparam logic [11:0] BTN_Y0     = 12'd200;
    localparam logic [11:0] BTN_W      = 12'd256;
    localparam logic [11:0] BTN_H      = 12'd64;
    localparam logic [11:0] BTN_GAP    = 12'd32;
    localparam int          N_BTN      = 3;
    localparam logic [11:0] SCR_W      = 12'd1024;
    localparam logic [11:0] SCR_H      = 12'd768;
    localparam logic [11:0] COL_IDLE   = 12'h888;
    localparam logic [11:0] COL_HOVER  = 12'hFF0;
    localparam logic [11:0] COL_PRESS  = 12'hF00;
    localparam logic [11:0] COL_BORDER = 12'hFFF;
    localparam logic [1:0]  IDLE       = 2'd0;
    localparam logic [1:0]  PRESSED    = 2'd1;
    localparam logic [1:0]  FIRE       = 2'd2;

    function automatic logic [11:0] btn_top(input logic [1:0] k);
        return BTN_Y0 + 12'(k) * (BTN_H + BTN_GAP);
    endfunction
endpackage

// File: rtl/menu_hit_test.sv
// menu_hit_test: maps a 12-bit x,y point to the button it falls on, if any
module menu_hit_test
    import menu_pkg::*;
(
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic        hit,
    output logic [1:0]  idx
);
    logic on_col;

    assign on_col = x >= BTN_X && x < BTN_X + BTN_W && x < SCR_W && y < SCR_H;

    always_comb begin
        hit = 1'b0;
        idx = 2'd0;
        for (int k = 0; k < N_BTN; k++) begin
            if (on_col && y >= btn_top(2'(k)) && y < btn_top(2'(k)) + BTN_H) begin
                hit = 1'b1;
                idx = 2'(k);
            end
        end
    end
endmodule

// File: rtl/menu_select.sv
// menu_select: button overlay and click selection over the menu background; define MENU_BORDER_EN for a 2-pixel white border
module menu_select
    import menu_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic        sel_valid,
    output logic [1:0]  sel_idx
);
    logic [11:0] mx, my, rgb_d, fill, rgb_nxt;
    logic [10:0] vcount_d, hcount_d;
    logic        vsync_d, hsync_d, vblnk_d, hblnk_d, hit_d, border_d;
    logic        hover_hit, pix_hit, pix_border;
    logic [1:0]  hover_idx, pix_idx, idx_d, press_idx, state, state_nxt;
    logic        ml_s1, ml_s2, ml_prev, press_e, release_e;

    menu_hit_test u_pix (.x({1'b0, hcount_in}), .y({1'b0, vcount_in}), .hit(pix_hit), .idx(pix_idx));
    menu_hit_test u_mouse (.x(mx), .y(my), .hit(hover_hit), .idx(hover_idx));

`ifdef MENU_BORDER_EN
    logic [11:0] rel_x, rel_y;
    assign rel_x = {1'b0, hcount_in} - BTN_X;
    assign rel_y = {1'b0, vcount_in} - btn_top(pix_idx);
    assign pix_border = pix_hit && (rel_x < 12'd2 || rel_x >= BTN_W - 12'd2 ||
                                    rel_y < 12'd2 || rel_y >= BTN_H - 12'd2);
`else
    assign pix_border = 1'b0;
`endif

    assign press_e   = ml_s2 && !ml_prev;
    assign release_e = !ml_s2 && ml_prev;

    // Mouse position only moves at the start of vertical blanking so a frame never tears
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            {ml_s1, ml_s2, ml_prev} <= '0;
            mx <= '0;
            my <= '0;
        end else begin
            ml_s1   <= mouse_left;
            ml_s2   <= ml_s1;
            ml_prev <= ml_s2;
            if (vblnk_in && !vblnk_d) begin
                mx <= xpos;
                my <= ypos;
            end
        end
    end

    assign fill    = (state == PRESSED && idx_d == press_idx) ? COL_PRESS :
                     (hover_hit && idx_d == hover_idx) ? COL_HOVER : COL_IDLE;
    assign rgb_nxt = (vblnk_d || hblnk_d) ? 12'h000 : !hit_d ? rgb_d : border_d ? COL_BORDER : fill;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            {vcount_d, hcount_d, vsync_d, hsync_d, vblnk_d, hblnk_d} <= '0;
            {rgb_d, hit_d, idx_d, border_d} <= '0;
            {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out} <= '0;
            rgb_out <= '0;
        end else begin
            {vcount_d, hcount_d, vsync_d, hsync_d, vblnk_d, hblnk_d} <=
                {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in};
            {rgb_d, hit_d, idx_d, border_d} <= {rgb_in, pix_hit, pix_idx, pix_border};
            {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out} <=
                {vcount_d, hcount_d, vsync_d, hsync_d, vblnk_d, hblnk_d};
            rgb_out <= rgb_nxt;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            press_idx <= '0;
            sel_idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && press_e && hover_hit)
                press_idx <= hover_idx;
            if (state_nxt == FIRE)
                sel_idx <= press_idx;
        end
    end

    // A click only counts when released over the same button it was pressed on
    always_comb begin
        state_nxt = (state == IDLE)    ? ((press_e && hover_hit) ? PRESSED : IDLE) :
                    (state == PRESSED) ? (!release_e ? PRESSED :
                                          (hover_hit && hover_idx == press_idx) ? FIRE : IDLE) :
                    IDLE;
    end

    always_comb begin
        sel_valid = (state == FIRE);
    end
endmodule

// File: tb/tb_menu_select.sv
// tb_menu_select: randomized self-checking bench for menu_select against a frame-level reference model
module tb_menu_select;
    logic        pclk = 1'b0, rst = 1'b0;
    logic [10:0] vcount_in = '0, hcount_in = '0;
    logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
    logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
    logic        mouse_left = 1'b0;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out, sel_valid;
    logic [11:0] rgb_out;
    logic [1:0]  sel_idx;

    always #5 pclk = ~pclk;

    menu_select dut (
        .pclk(pclk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .sel_valid(sel_valid), .sel_idx(sel_idx)
    );

    int n_cmp = 0, n_err = 0, pulses = 0, exp_pulses = 0;
    int mx_m = 0, my_m = 0, pidx_m = 0;
    bit pressed_m = 0, prev_vb = 0;
    logic [1:0] exp_sel = '0;
    logic [11:0] q_rgb[$];
    logic [25:0] q_tim[$];
    string q_tag[$];

    always @(negedge pclk) if (sel_valid) pulses++;

    function automatic int ref_btn(int x, int y);
        if (x < 384 || x >= 640 || x >= 1024 || y >= 768) return -1;
        for (int k = 0; k < 3; k++)
            if (y >= 200 + 96 * k && y < 264 + 96 * k) return k;
        return -1;
    endfunction

    function automatic logic [11:0] ref_rgb(int h, int v, logic [11:0] bg, bit hb, bit vb);
        int b;
        b = ref_btn(h, v);
        if (hb || vb) return 12'h000;
        if (b < 0) return bg;
`ifdef MENU_BORDER_EN
        if (h - 384 < 2 || h >= 638 || v - (200 + 96 * b) < 2 || v >= 262 + 96 * b) return 12'hFFF;
`endif
        if (pressed_m && b == pidx_m) return 12'hF00;
        if (b == ref_btn(mx_m, my_m)) return 12'hFF0;
        return 12'h888;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_front();
        string t;
        t = q_tag.pop_front();
        check({t, "_rgb"}, 32'(rgb_out), 32'(q_rgb.pop_front()));
        check({t, "_timing"}, 32'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}),
              32'(q_tim.pop_front()));
    endtask

    task automatic step(int h, int v, logic [11:0] bg, bit hb, bit vb, string tag);
        logic [1:0] s;
        s = 2'($urandom);
        hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = bg;
        hblnk_in = hb; vblnk_in = vb; hsync_in = s[0]; vsync_in = s[1];
        q_rgb.push_back(ref_rgb(h, v, bg, hb, vb));
        q_tim.push_back({11'(v), 11'(h), s[1], s[0], vb, hb});
        q_tag.push_back(tag);
        if (vb && !prev_vb) begin mx_m = int'(xpos); my_m = int'(ypos); end
        prev_vb = vb;
        @(posedge pclk); #1;
        if (q_rgb.size() == 2) compare_front();
    endtask

    task automatic flush();
        @(posedge pclk); #1;
        if (q_rgb.size() == 1) compare_front();
    endtask

    task automatic set_mouse(int x, int y);
        xpos = 12'(x); ypos = 12'(y);
        step(0, 0, 12'($urandom), 0, 0, "pre_vbl");
        step(0, 0, 12'($urandom), 0, 1, "vbl");
        step(0, 0, 12'($urandom), 0, 0, "post_vbl");
        flush();
    endtask

    task automatic press();
        mouse_left = 1'b1;
        repeat (5) @(posedge pclk);
        #1;
        if (ref_btn(mx_m, my_m) >= 0) begin pressed_m = 1; pidx_m = ref_btn(mx_m, my_m); end
    endtask

    task automatic release_btn(string tag);
        mouse_left = 1'b0;
        repeat (6) @(posedge pclk);
        #1;
        if (pressed_m && ref_btn(mx_m, my_m) == pidx_m) begin exp_pulses++; exp_sel = 2'(pidx_m); end
        pressed_m = 0;
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        check({tag, "_sel_idx"}, 32'(sel_idx), 32'(exp_sel));
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("reset_rgb", 32'(rgb_out), 32'h0);
        check("reset_sel", 32'({sel_valid, sel_idx}), 32'h0);
        check("reset_timing", 32'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}), 32'h0);
        rst = 1'b1;
        @(posedge pclk); #1;

        step(384, 200, 12'h123, 0, 0, "btn0_corner");
        step(640, 200, 12'h456, 0, 0, "right_excl");
        step(383, 200, 12'h789, 0, 0, "left_excl");
        step(639, 263, 12'hABC, 0, 0, "btn0_far");
        step(500, 264, 12'hDEF, 0, 0, "bottom_excl");
        step(385, 230, 12'h321, 0, 0, "border_px");
        step(390, 230, 12'h654, 0, 0, "fill_px");
        flush();

        set_mouse(400, 300);
        step(500, 220, 12'h111, 0, 0, "hov_b0");
        step(500, 320, 12'h222, 0, 0, "hov_b1");
        step(500, 420, 12'h333, 0, 0, "hov_b2");
        flush();

        set_mouse(500, 400);
        press();
        step(500, 420, 12'h444, 0, 0, "held_b2");
        step(500, 320, 12'h555, 0, 0, "held_b1");
        flush();
        release_btn("click_b2");

        set_mouse(400, 220);
        press();
        set_mouse(400, 300);
        release_btn("moved_off");
        step(500, 220, 12'h666, 0, 0, "idle_after_cancel");
        flush();

        set_mouse(450, 300);
        press();
        set_mouse(100, 100);
        set_mouse(450, 300);
        release_btn("drag_back");

        set_mouse(100, 100);
        press();
        set_mouse(400, 220);
        release_btn("press_nohit");
        step(500, 230, 12'h777, 0, 0, "hover_after_nohit");
        step(400, 220, 12'h999, 1, 0, "hblank_btn");
        flush();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                xpos = 12'($urandom_range(300, 1100));
                ypos = 12'($urandom_range(150, 800));
            end
            step($urandom_range(370, 660), $urandom_range(190, 470), 12'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, "rnd_px");
        end
        flush();

        for (int i = 0; i < 10; i++) begin
            set_mouse($urandom_range(360, 660), $urandom_range(180, 470));
            press();
            if ($urandom_range(0, 1) == 1) set_mouse($urandom_range(360, 660), $urandom_range(180, 470));
            step($urandom_range(390, 630), 210 + 96 * $urandom_range(0, 2), 12'($urandom), 0, 0, "rnd_click_px");
            flush();
            release_btn("rnd_click");
        end

        set_mouse(400, 220);
        press();
        rst = 1'b0;
        #1;
        mx_m = 0; my_m = 0; pressed_m = 0; exp_sel = '0; prev_vb = 0;
        check("rst_mid_rgb", 32'(rgb_out), 32'h0);
        check("rst_mid_sel", 32'({sel_valid, sel_idx}), 32'h0);
        check("rst_mid_timing", 32'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}), 32'h0);
        mouse_left = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge pclk);
        #1;
        check("rst_no_pulse", 32'(pulses), 32'(exp_pulses));
        step(500, 220, 12'hBBB, 0, 0, "post_rst_idle");
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
